fpsub_unsigned: RTL and testbench

- Iterative magnitude subtractor for the 31-bit unsigned FP format: [30:23] exponent, [22:0] fraction, implicit leading 1.
- It is the inverse of the unsigned FP adder: computes |in1 - in2| and reports which operand was larger.
- It needs the leading-zero renormalization that addition never does.
- Sits beside the adder in the FP functional unit. The reservation-station side drives the valid/ready handshake in; the CDB arbiter drains it out.

---
 rtl/fp_pkg.sv | 19 +
 rtl/fp_lzc24.sv | 13 +
 rtl/fpsub_unsigned.sv | 98 +++++++++
 tb/tb_fpsub_unsigned.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the unsigned FP adder/subtractor
// Format: [30:23] exponent, [22:0] fraction, implicit leading 1.
// Provides widths, the unit FSM state type and field-extract helpers.
package fp_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int FP_W  = EXP_W + MAN_W;

    typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

    function automatic logic [EXP_W-1:0] fp_exp(input logic [FP_W-1:0] x);
        return x[FP_W-1:MAN_W];
    endfunction

    // Fraction with the implicit leading 1 restored
    function automatic logic [MAN_W:0] fp_man(input logic [FP_W-1:0] x);
        return {1'b1, x[MAN_W-1:0]};
    endfunction
endpackage

// File: rtl/fp_lzc24.sv
// fp_lzc24: 24-bit leading-zero counter
// Ports: i_val - value to scan; o_lzc - leading zeros (24 when i_val is 0).
module fp_lzc24 (
    input  logic [23:0] i_val,
    output logic [4:0]  o_lzc
);
    // Ascending scan: the highest set bit is the last one to write
    always_comb begin
        o_lzc = 5'd24;
        for (int i = 0; i < 24; i++)
            if (i_val[i]) o_lzc = 5'(23 - i);
    end
endmodule

// File: rtl/fpsub_unsigned.sv
// fpsub_unsigned: iterative magnitude subtractor |in1 - in2| for unsigned FP
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in1/in2 operand
// handshake; out_valid/out_ready/result/result_neg result handshake.
// Macro FPSUB_LZC_EN: single-cycle normalization via fp_lzc24 instead of
// one-bit-per-cycle left shifting.
module fpsub_unsigned
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in1,
    input  logic [FP_W-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] result,
    output logic            result_neg
);
    state_t           r_state;
    logic [FP_W-1:0]  r_l, r_s;
    logic [MAN_W:0]   r_ms, r_m;
    logic [EXP_W-1:0] r_e;
    logic             w_swap;
    logic [EXP_W-1:0] w_d;
    logic [MAN_W:0]   w_ms;

    assign in_ready  = r_state == IDLE;
    assign out_valid = r_state == DONE;
    // Plain unsigned compare of the packed words orders magnitudes correctly
    assign w_swap = in2 > in1;
    assign w_d    = fp_exp(r_l) - fp_exp(r_s);
    assign w_ms   = w_d >= 8'd24 ? '0 : fp_man(r_s) >> w_d;

`ifdef FPSUB_LZC_EN
    logic [4:0]       w_lzc;
    logic [EXP_W-1:0] w_lim, w_sh, w_en;
    logic [MAN_W:0]   w_mn;

    fp_lzc24 u_lzc (.i_val(r_m), .o_lzc(w_lzc));

    // Never shift the exponent below 1; anything still unnormalized flushes
    assign w_lim = r_e - 8'd1;
    assign w_sh  = {3'b0, w_lzc} < w_lim ? {3'b0, w_lzc} : w_lim;
    assign w_mn  = r_m << w_sh;
    assign w_en  = r_e - w_sh;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            result     <= '0;
            result_neg <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_l        <= w_swap ? in2 : in1;
                    r_s        <= w_swap ? in1 : in2;
                    result_neg <= w_swap;
                    r_state    <= ALIGN;
                end
                ALIGN: begin
                    r_ms    <= w_ms;
                    r_state <= SUB;
                end
                SUB: begin
                    r_m     <= fp_man(r_l) - r_ms;
                    r_e     <= fp_exp(r_l);
                    r_state <= NORM;
                end
`ifdef FPSUB_LZC_EN
                NORM: begin
                    result  <= w_mn[MAN_W] ? {w_en, w_mn[MAN_W-1:0]} : '0;
                    r_state <= DONE;
                end
`else
                NORM: begin
                    if (r_m == '0) begin
                        result  <= '0;
                        r_state <= DONE;
                    end else if (r_m[MAN_W]) begin
                        result  <= {r_e, r_m[MAN_W-1:0]};
                        r_state <= DONE;
                    end else if (r_e == 8'd1) begin
                        result  <= '0;
                        r_state <= DONE;
                    end else begin
                        r_m <= r_m << 1;
                        r_e <= r_e - 8'd1;
                    end
                end
`endif
                DONE: if (out_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpsub_unsigned.sv
// tb_fpsub_unsigned: directed and random checks of fpsub_unsigned against a reference model
module tb_fpsub_unsigned;
    logic        clk = 0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, result_neg;
    logic [30:0] in1, in2, result;
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    fpsub_unsigned dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_neg(result_neg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference: exact integer mantissa arithmetic, then normalize by the
    // position of the leading one, flushing if the exponent would drop below 1.
    function automatic void model(input logic [30:0] a, input logic [30:0] b,
                                  output logic [30:0] r, output logic neg, output int k);
        logic [30:0] l, s;
        longint ml, ms, diff, frac;
        int el, es, d, p, n;
        neg = b > a;
        l = neg ? b : a;
        s = neg ? a : b;
        el = int'(l[30:23]);
        es = int'(s[30:23]);
        d = el - es;
        ml = 64'd8388608 + longint'(l[22:0]);
        ms = 64'd8388608 + longint'(s[22:0]);
        ms = d >= 24 ? 0 : ms / (64'd1 << d);
        diff = ml - ms;
        r = '0;
        k = 0;
        if (diff != 0) begin
            p = 0;
            for (int i = 0; i < 24; i++) if (diff >= (64'd1 << i)) p = i;
            n = 23 - p;
            if (n > el - 1) k = el - 1;
            else begin
                k = n;
                frac = (diff * (64'd1 << n)) % 64'd8388608;
                r = 31'(longint'(el - n) * 64'd8388608 + frac);
            end
        end
    endfunction

    task automatic do_op(input logic [30:0] a, input logic [30:0] b, input int stall, input bit poke);
        logic [30:0] er;
        logic        en;
        int          k, lat, cyc;
        model(a, b, er, en, k);
`ifdef FPSUB_LZC_EN
        lat = 3;
`else
        lat = 3 + k;
`endif
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1; out_ready = 0;
        @(posedge clk); #1;
        in_valid = poke;
        if (poke) begin
            in1 = 31'h3F800000; in2 = 31'h3FC00000;
        end
        cyc = 0;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 1) chk("busy_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 0;
        chk("latency", cyc, lat);
        chk("result", 32'(result), 32'(er));
        chk("neg", 32'(result_neg), 32'(en));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_result", 32'(result), 32'(er));
            chk("hold_neg", 32'(result_neg), 32'(en));
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [30:0] a, b;
        int ea, eb;
        rst = 1; in_valid = 0; out_ready = 0; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_neg", 32'(result_neg), 32'd0);

        do_op(31'h3FC00000, 31'h3F800000, 0, 0);
        chk("1.5-1.0", 32'(result), 32'h3F000000);
        do_op(31'h3F800000, 31'h3FC00000, 0, 0);
        chk("swap_neg", 32'(result_neg), 32'd1);
        do_op(31'h40490FDB, 31'h40490FDB, 0, 0);
        do_op(31'h4B800000, 31'h3F800000, 0, 0);
        chk("d24", 32'(result), 32'h4B800000);
        do_op(31'h00C00000, 31'h00800000, 0, 1);
        do_op(31'h3FC00000, 31'h3F800000, 5, 0);

        // Abort in NORM: E0 capture, E1 ALIGN, E2 SUB->NORM, reset at E3
        @(negedge clk);
        in1 = 31'h3F800001; in2 = 31'h3F800000; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_neg", 32'(result_neg), 32'd0);

        for (int t = 0; t < 40; t++) begin
            ea = int'($urandom_range(1, 254));
            eb = (t % 2 == 0) ? ea + int'($urandom_range(0, 4)) - 2 : int'($urandom_range(1, 254));
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            a = {8'(ea), 23'($urandom)};
            b = {8'(eb), 23'($urandom)};
            if (t % 5 == 0) b = {8'(ea), a[22:0] ^ 23'($urandom_range(1, 255))};
            do_op(a, b, t % 3, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
